// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes,
// instruction field positions and the write-buffer depth.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_ILL = 2'd3
  } fmt_e;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int REG_W      = 5;
  localparam int FUNC_LSB   = 0;
  localparam int FUNC_W     = 6;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;
  localparam int INDEX_LSB  = 0;
  localparam int INDEX_W    = 26;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input channel and instruction-memory write channel of the
// encoder. The master side offers bundles and accepts writes.
interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic        in_valid;
  logic        in_ready;
  fmt_e        fmt;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [25:0] instr_index;
  logic        base_load;
  logic [31:0] base_addr;
  logic        wr_en;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        err_illegal;
  logic [15:0] word_count;

  modport master (
    output in_valid, fmt, opcode, func, rs, rt, rd, shamt, immediate,
           instr_index, base_load, base_addr, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, err_illegal, word_count
  );

  modport slave (
    input  in_valid, fmt, opcode, func, rs, rt, rd, shamt, immediate,
           instr_index, base_load, base_addr, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, err_illegal, word_count
  );

endinterface

// File: rtl/instr_encoder_fifo.sv
// Small synchronous FIFO buffering encoded words between acceptance and
// the memory write. Push is ignored when full, pop is ignored when empty.
module instr_fifo
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);

  logic [31:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word storage; contents need no reset because occupancy guards them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes R/I/J field bundles into 32-bit instruction words, buffers them
// and writes them to consecutive word addresses of instruction memory.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  instr_encoder_if.slave  bus
);

  logic [31:0] enc_word;
  logic [31:0] fifo_head;
  logic [31:0] wr_addr_q;
  logic [15:0] word_count_q;
  logic        err_q;
  logic        run_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        wr_done;

  assign bus.in_ready    = run_q && !fifo_full;
  assign accept          = bus.in_valid && bus.in_ready;
  assign push            = accept && (bus.fmt != FMT_ILL);
  assign bus.wr_en       = !fifo_empty;
  assign wr_done         = bus.wr_en && bus.wr_ready;
  assign bus.wr_data     = fifo_empty ? 32'h0 : fifo_head;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.word_count  = word_count_q;
  assign bus.err_illegal = err_q;

  // Assemble the instruction word; fields the format does not use are dropped.
  always_comb begin
    enc_word = '0;
    enc_word[OPCODE_LSB +: OPCODE_W] = bus.opcode;
    case (bus.fmt)
      FMT_R: begin
        enc_word[RS_LSB    +: REG_W]  = bus.rs;
        enc_word[RT_LSB    +: REG_W]  = bus.rt;
        enc_word[RD_LSB    +: REG_W]  = bus.rd;
        enc_word[SHAMT_LSB +: REG_W]  = bus.shamt;
        enc_word[FUNC_LSB  +: FUNC_W] = bus.func;
      end
      FMT_I: begin
        enc_word[RS_LSB  +: REG_W] = bus.rs;
        enc_word[RT_LSB  +: REG_W] = bus.rt;
        enc_word[IMM_LSB +: IMM_W] = bus.immediate;
      end
      FMT_J: begin
        enc_word[INDEX_LSB +: INDEX_W] = bus.instr_index;
      end
      default: enc_word = '0;
    endcase
  end

  instr_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (enc_word),
    .pop       (wr_done),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Hold off acceptance until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Write pointer: a base load overrides the post-write increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          wr_addr_q <= 32'h0;
    else if (bus.base_load) wr_addr_q <= {bus.base_addr[31:2], 2'b00};
    else if (wr_done)      wr_addr_q <= wr_addr_q + 32'd4;
  end

  // Completed-write counter and one-cycle illegal-format flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count_q <= 16'h0;
      err_q        <= 1'b0;
    end else begin
      if (wr_done) word_count_q <= word_count_q + 16'd1;
      err_q <= accept && (bus.fmt == FMT_ILL);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder with hand-written
// sequences for back-pressure, wrap, reset and base-load collisions.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  typedef struct {
    fmt_e        fmt;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] idx;
    logic        illegal;
    logic [31:0] exp_data;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   fails;
  logic [31:0] exp_addr;
  logic [15:0] exp_count;
  vec_t vecs [7];
  vec_t bp   [5];

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.in_valid    = 1'b1;
    bus.fmt         = v.fmt;
    bus.opcode      = v.opcode;
    bus.func        = v.func;
    bus.rs          = v.rs;
    bus.rt          = v.rt;
    bus.rd          = v.rd;
    bus.shamt       = v.shamt;
    bus.immediate   = v.imm;
    bus.instr_index = v.idx;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadBase(input logic [31:0] a);
    bus.base_load = 1'b1;
    bus.base_addr = a;
    step();
    bus.base_load = 1'b0;
    exp_addr = {a[31:2], 2'b00};
  endtask

  initial begin
    int n;
    logic acc;
    checks = 0;
    fails  = 0;
    exp_addr  = 32'h0;
    exp_count = 16'h0;

    vecs[0] = '{FMT_R, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0000000, 1'b0, 32'h00221820};
    vecs[1] = '{FMT_I, 6'h09, 6'h3F, 5'd0, 5'd8, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h2408FFFF};
    vecs[2] = '{FMT_J, 6'h02, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000C00, 1'b0, 32'h08000C00};
    vecs[3] = '{FMT_R, 6'h00, 6'h02, 5'd31, 5'd0, 5'd17, 5'd5, 16'hABCD, 26'h1234567, 1'b0, 32'h03E08942};
    vecs[4] = '{FMT_ILL, 6'h3F, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 16'h1111, 26'h2222222, 1'b1, 32'h00000000};
    vecs[5] = '{FMT_I, 6'h23, 6'h00, 5'd29, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0000000, 1'b0, 32'h8FA40010};
    vecs[6] = '{FMT_J, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FFFFFF, 1'b0, 32'h0FFFFFFF};

    for (int k = 0; k < 5; k++) begin
      bp[k] = '{FMT_I, 6'h09, 6'h00, 5'd0, 5'(k), 5'd0, 5'd0, 16'(k + 1), 26'h0, 1'b0,
                32'h24000000 | (32'(k) << 16) | 32'(k + 1)};
    end

    bus.in_valid = 1'b0;
    bus.fmt = FMT_R;
    bus.opcode = '0; bus.func = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
    bus.shamt = '0; bus.immediate = '0; bus.instr_index = '0;
    bus.base_load = 1'b0;
    bus.base_addr = '0;
    bus.wr_ready = 1'b0;
    reset_n = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_wr_en", bus.wr_en, 0);
    checkOutput("rst_wr_addr", bus.wr_addr, 0);
    checkOutput("rst_wr_data", bus.wr_data, 0);
    checkOutput("rst_err", bus.err_illegal, 0);
    checkOutput("rst_count", bus.word_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    // Table of single bundles, each written one cycle after acceptance
    loadBase(32'h00003000);
    checkOutput("base_load_addr", bus.wr_addr, exp_addr);
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
      applyStimulus(vecs[i]);
      step();
      idle();
      if (vecs[i].illegal) begin
        checkOutput($sformatf("vec%0d_err", i), bus.err_illegal, 1);
        checkOutput($sformatf("vec%0d_no_write", i), bus.wr_en, 0);
        step();
        checkOutput($sformatf("vec%0d_err_cleared", i), bus.err_illegal, 0);
        checkOutput($sformatf("vec%0d_still_no_write", i), bus.wr_en, 0);
        checkOutput($sformatf("vec%0d_count", i), bus.word_count, 32'(exp_count));
      end else begin
        checkOutput($sformatf("vec%0d_err", i), bus.err_illegal, 0);
        checkOutput($sformatf("vec%0d_wr_en", i), bus.wr_en, 1);
        checkOutput($sformatf("vec%0d_data", i), bus.wr_data, vecs[i].exp_data);
        checkOutput($sformatf("vec%0d_addr", i), bus.wr_addr, exp_addr);
        step();
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 16'd1;
        checkOutput($sformatf("vec%0d_done", i), bus.wr_en, 0);
        checkOutput($sformatf("vec%0d_count", i), bus.word_count, 32'(exp_count));
        checkOutput($sformatf("vec%0d_next_addr", i), bus.wr_addr, exp_addr);
      end
    end

    // Back-to-back I then J with simultaneous push and pop
    loadBase(32'h00003000);
    applyStimulus(vecs[1]);
    step();
    applyStimulus(vecs[2]);
    checkOutput("mix_i_data", bus.wr_data, 32'h2408FFFF);
    checkOutput("mix_i_addr", bus.wr_addr, 32'h00003000);
    step();
    idle();
    checkOutput("mix_j_data", bus.wr_data, 32'h08000C00);
    checkOutput("mix_j_addr", bus.wr_addr, 32'h00003004);
    step();
    exp_count = exp_count + 16'd2;
    checkOutput("mix_empty", bus.wr_en, 0);
    checkOutput("mix_count", bus.word_count, 32'(exp_count));

    // Back-pressure: four bundles fill the buffer, the fifth waits
    loadBase(32'h00004000);
    bus.wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("bp%0d_in_ready", k), bus.in_ready, 1);
      applyStimulus(bp[k]);
      step();
    end
    applyStimulus(bp[4]);
    checkOutput("bp_full_in_ready", bus.in_ready, 0);
    checkOutput("bp_wr_en", bus.wr_en, 1);
    checkOutput("bp_head", bus.wr_data, bp[0].exp_data);
    step();
    checkOutput("bp_still_full", bus.in_ready, 0);
    checkOutput("bp_head_held", bus.wr_data, bp[0].exp_data);
    checkOutput("bp_addr_held", bus.wr_addr, 32'h00004000);
    bus.wr_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (bus.wr_en) begin
        checkOutput($sformatf("bp_write%0d_data", n), bus.wr_data, bp[n].exp_data);
        checkOutput($sformatf("bp_write%0d_addr", n), bus.wr_addr, exp_addr);
        n++;
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 16'd1;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) idle();
    end
    idle();
    checkOutput("bp_write_total", 32'(n), 32'd5);
    checkOutput("bp_count", bus.word_count, 32'(exp_count));

    // Address wrap, with low base bits discarded
    loadBase(32'hFFFFFFFF);
    checkOutput("wrap_base", bus.wr_addr, 32'hFFFFFFFC);
    applyStimulus(vecs[0]);
    step();
    applyStimulus(vecs[3]);
    checkOutput("wrap_addr0", bus.wr_addr, 32'hFFFFFFFC);
    step();
    idle();
    checkOutput("wrap_addr1", bus.wr_addr, 32'h00000000);
    checkOutput("wrap_data1", bus.wr_data, vecs[3].exp_data);
    step();
    exp_count = exp_count + 16'd2;
    checkOutput("wrap_after", bus.wr_addr, 32'h00000004);
    checkOutput("wrap_count", bus.word_count, 32'(exp_count));

    // Reset with three words buffered and an error pulse pending
    bus.wr_ready = 1'b0;
    applyStimulus(vecs[0]); step();
    applyStimulus(vecs[1]); step();
    applyStimulus(vecs[2]); step();
    applyStimulus(vecs[4]); step();
    idle();
    checkOutput("pre_rst_err", bus.err_illegal, 1);
    checkOutput("pre_rst_wr_en", bus.wr_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_en", bus.wr_en, 0);
    checkOutput("mid_rst_addr", bus.wr_addr, 0);
    checkOutput("mid_rst_data", bus.wr_data, 0);
    checkOutput("mid_rst_count", bus.word_count, 0);
    checkOutput("mid_rst_err", bus.err_illegal, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_count = 16'h0;
    step();
    checkOutput("post_mid_rst_in_ready", bus.in_ready, 1);
    checkOutput("post_mid_rst_empty", bus.wr_en, 0);

    // Base load coinciding with a completed write
    loadBase(32'h00000200);
    applyStimulus(vecs[0]); step();
    applyStimulus(vecs[3]); step();
    idle();
    checkOutput("coll_old_addr", bus.wr_addr, 32'h00000200);
    checkOutput("coll_old_data", bus.wr_data, vecs[0].exp_data);
    bus.base_load = 1'b1;
    bus.base_addr = 32'h00000100;
    bus.wr_ready  = 1'b1;
    step();
    bus.base_load = 1'b0;
    bus.wr_ready  = 1'b0;
    checkOutput("coll_new_addr", bus.wr_addr, 32'h00000100);
    checkOutput("coll_next_data", bus.wr_data, vecs[3].exp_data);
    checkOutput("coll_count", bus.word_count, 1);
    bus.wr_ready = 1'b1;
    step();
    checkOutput("coll_after_addr", bus.wr_addr, 32'h00000104);
    checkOutput("coll_after_empty", bus.wr_en, 0);
    checkOutput("coll_after_count", bus.word_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  field bundle offered this cycle.
REQ-004 in_ready  out  1  encoder can accept a bundle; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-005 fmt  in  2  0=R, 1=I, 2=J, 3=illegal.
REQ-006 opcode  in  6  instruction bits [31:26].
REQ-007 func  in  6  R-type bits [5:0].
REQ-008 rs, rt, rd  in  5 each  register fields.
REQ-009 shamt  in  5  R-type bits [10:6].
REQ-010 immediate  in  16  I-type bits [15:0].
REQ-011 instr_index  in  26  J-type bits [25:0].
REQ-012 base_load  in  1  load the write pointer.
REQ-013 base_addr  in  32  byte address to load; bits [1:0] are ignored and forced to 0.
REQ-014 wr_en  out  1  instruction-memory write request.
REQ-015 wr_ready  in  1  memory accepts the write; a write completes when wr_en and wr_ready are both 1.
REQ-016 wr_addr  out  32  byte address of the current write.
REQ-017 wr_data  out  32  encoded instruction word.
REQ-018 err_illegal  out  1  one-cycle pulse when an accepted bundle has fmt=3.
REQ-019 word_count  out  16  number of completed writes since reset; wraps modulo 2^16.

Function
REQ-020 Encoding rules:
- R-type: {opcode, rs, rt, rd, shamt, func}.
- I-type: {opcode, rs, rt, immediate}.
- J-type: {opcode, instr_index}.
- Fields unused by the selected format are ignored.
REQ-021 Each accepted legal bundle is encoded and pushed into a 4-entry FIFO in the cycle it is accepted.
REQ-022 An accepted fmt=3 bundle is dropped (nothing pushed), and err_illegal is 1 in the following cycle only.
REQ-023 in_ready = FIFO not full; it is combinational from FIFO occupancy only and never depends on in_valid or wr_ready.
REQ-024 When the FIFO is full, in_ready is 0 even if a write completes in the same cycle (no full-pass-through).
REQ-025 wr_en = FIFO not empty; wr_data = FIFO head. Minimum latency from acceptance edge to wr_en high is 1 cycle.
REQ-026 While wr_en is 1 and wr_ready is 0, wr_en, wr_data and wr_addr are held stable.
REQ-027 On a completed write:
- the FIFO pops;
- wr_addr increments by 4, wrapping 0xFFFFFFFC -> 0x00000000;
- word_count increments.
REQ-028 Simultaneous push and pop when the FIFO is not full and not empty: occupancy is unchanged and order is preserved.
REQ-029 Pushing into an empty FIFO while wr_ready is 1: the word is written no earlier than the next cycle.
REQ-030 base_load sets wr_addr to {base_addr[31:2], 2'b00} at the next edge.
REQ-031 If base_load coincides with a completed write, that write uses the old wr_addr and base_load wins the pointer update (no +4 applied).
REQ-032 base_load does not flush or modify FIFO contents.
REQ-033 Words are written in acceptance order; none are lost or duplicated.

Reset
REQ-034 While reset_n=0, all of the following are forced asynchronously:
- FIFO empty;
- in_ready=0 while reset_n is low, then 1 from the first cycle after release;
- wr_en=0, wr_addr=0x00000000, wr_data=0x00000000;
- err_illegal=0, word_count=0.
REQ-035 Reset asserted mid-operation discards all buffered words and any pending err_illegal pulse.

Structure
REQ-036 A shared package holds the fmt codes (FMT_R, FMT_I, FMT_J, FMT_ILL), the field bit positions, and FIFO_DEPTH=4.
REQ-037 The FIFO is a sub-module, instr_fifo: synchronous push/pop, registered storage, full/empty flags, same clk/reset_n.
REQ-038 Encoding logic is combinational inside instr_encoder; no further sub-modules.

Verification
REQ-039 Encoding: R add $3,$1,$2 (op 0, rs 1, rt 2, rd 3, shamt 0, func 0x20), base 0x00003000, wr_ready=1 -> wr_data 0x00221820 at wr_addr 0x00003000, one cycle after acceptance.
REQ-040 Format mix: I addiu op 0x09, rs 0, rt 8, imm 0xFFFF, then J op 0x02, index 0x0000C00 -> writes 0x2408FFFF @0x00003000, then 0x08000C00 @0x00003004; word_count=2.
REQ-041 Back-pressure: wr_ready=0, five back-to-back bundles -> in_ready drops after 4 acceptances; wr_data is held. Release wr_ready -> 5 writes in order at consecutive addresses.
REQ-042 Illegal format and wrap: fmt=3 -> err_illegal high exactly 1 cycle, no write. Separately, base 0xFFFFFFFC with two writes -> addresses 0xFFFFFFFC, then 0x00000000.
REQ-043 Reset and base collision: reset_n low with 3 words buffered -> wr_en=0 and counters zero immediately. Separately, base_load 0x100 coincident with a completed write -> that write goes to the old address; the next write goes to 0x100.
